// File: rtl/tft_panel_seq.sv
// rtl/tft_panel_seq.sv - TFT panel power/enable sequencer with backlight PWM ramp
module tft_panel_seq #(
  parameter int T_PWR      = 1000,
  parameter int T_DISP     = 500,
  parameter int PRE_FRAMES = 2,
  parameter int BL_STEP    = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_screenend,
  input  logic [7:0] i_bl_level,
  output logic       o_avdd_en,
  output logic       o_tg_rst,
  output logic       o_pix_en,
  output logic       o_disp,
  output logic       o_bl_pwm,
  output logic       o_ready,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_TG_RUN  = 3'd2,
    S_DISP_ON = 3'd3,
    S_BL_UP   = 3'd4,
    S_ON      = 3'd5,
    S_BL_DOWN = 3'd6,
    S_PWR_DN  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_WAIT_FRAME = 2'd0,
    PH_DISP_OFF   = 2'd1,
    PH_PWR_OFF    = 2'd2
  } phase_t;

  localparam logic [23:0] PWR_LAST   = 24'(T_PWR - 1);
  localparam logic [23:0] DISP_LAST  = 24'(T_DISP - 1);
  localparam logic [23:0] STEP_LAST  = 24'(BL_STEP - 1);
  localparam logic [3:0]  FRAME_LAST = 4'(PRE_FRAMES - 1);

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [23:0] timer, timer_d;
  logic [3:0]  fcnt, fcnt_d;
  logic [7:0]  duty, duty_d;
  logic [7:0]  pwm_cnt;
  logic        avdd_d, tg_rst_d, pix_en_d, disp_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_OFF;
      phase     <= PH_WAIT_FRAME;
      timer     <= '0;
      fcnt      <= '0;
      duty      <= '0;
      pwm_cnt   <= '0;
      o_avdd_en <= 1'b0;
      o_tg_rst  <= 1'b1;
      o_pix_en  <= 1'b0;
      o_disp    <= 1'b0;
      o_bl_pwm  <= 1'b0;
      o_ready   <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      timer     <= timer_d;
      fcnt      <= fcnt_d;
      duty      <= duty_d;
      pwm_cnt   <= pwm_cnt + 8'd1;
      o_avdd_en <= avdd_d;
      o_tg_rst  <= tg_rst_d;
      o_pix_en  <= pix_en_d;
      o_disp    <= disp_d;
      o_bl_pwm  <= (pwm_cnt < duty);
      o_ready   <= (state_d == S_ON);
    end
  end

  always_comb begin
    state_d  = state;
    phase_d  = phase;
    timer_d  = timer + 24'd1;
    fcnt_d   = fcnt;
    duty_d   = duty;
    avdd_d   = o_avdd_en;
    tg_rst_d = o_tg_rst;
    pix_en_d = o_pix_en;
    disp_d   = o_disp;

    case (state)
      S_OFF:     if (i_en) state_d = S_PWR_UP;
      S_PWR_UP:  if (timer == PWR_LAST) state_d = S_TG_RUN;
      S_TG_RUN: begin
        if (i_screenend) begin
          if (fcnt == FRAME_LAST) state_d = S_DISP_ON;
          else fcnt_d = fcnt + 4'd1;
        end
      end
      S_DISP_ON: if (timer == DISP_LAST) state_d = S_BL_UP;
      S_BL_UP: begin
        if (duty >= i_bl_level) begin
          state_d = S_ON;
          duty_d  = i_bl_level;
        end else if (timer == STEP_LAST) begin
          duty_d  = duty + 8'd1;
          timer_d = '0;
        end
      end
      S_ON:      duty_d = i_bl_level;
      S_BL_DOWN: begin
        if (duty == 8'd0) begin
          state_d = S_PWR_DN;
          // Without DISP raised there is no frame to finish: stop the generator now.
          if (o_disp) begin
            phase_d = PH_WAIT_FRAME;
          end else begin
            phase_d  = PH_PWR_OFF;
            tg_rst_d = 1'b1;
            pix_en_d = 1'b0;
          end
        end else if (timer == STEP_LAST) begin
          duty_d  = duty - 8'd1;
          timer_d = '0;
        end
      end
      S_PWR_DN: begin
        case (phase)
          PH_WAIT_FRAME: if (i_screenend) begin
            disp_d  = 1'b0;
            phase_d = PH_DISP_OFF;
            timer_d = '0;
          end
          PH_DISP_OFF: if (timer == DISP_LAST) begin
            tg_rst_d = 1'b1;
            pix_en_d = 1'b0;
            phase_d  = PH_PWR_OFF;
            timer_d  = '0;
          end
          default: if (timer == PWR_LAST) begin
            avdd_d  = 1'b0;
            state_d = S_OFF;
          end
        endcase
      end
      default: state_d = S_OFF;
    endcase

    if (!i_en && (state inside {S_PWR_UP, S_TG_RUN, S_DISP_ON, S_BL_UP, S_ON})) begin
      state_d = S_BL_DOWN;
      duty_d  = duty;
    end

    if (state_d != state) timer_d = '0;
    if (state_d == S_TG_RUN && state != S_TG_RUN) fcnt_d = '0;

    // Pin levels for the forward states; the shutdown states hold/edit them above.
    case (state_d)
      S_OFF:    begin avdd_d = 1'b0; tg_rst_d = 1'b1; pix_en_d = 1'b0; disp_d = 1'b0; end
      S_PWR_UP: begin avdd_d = 1'b1; tg_rst_d = 1'b1; pix_en_d = 1'b0; disp_d = 1'b0; end
      S_TG_RUN: begin avdd_d = 1'b1; tg_rst_d = 1'b0; pix_en_d = 1'b1; disp_d = 1'b0; end
      S_DISP_ON, S_BL_UP, S_ON: begin
        avdd_d = 1'b1; tg_rst_d = 1'b0; pix_en_d = 1'b1; disp_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_tft_panel_seq.sv
// tb/tb_tft_panel_seq.sv - directed scoreboard bench for tft_panel_seq
module tb_tft_panel_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_screenend = 1'b0;
  logic [7:0] i_bl_level = 8'd0;
  logic       o_avdd_en, o_tg_rst, o_pix_en, o_disp, o_bl_pwm, o_ready;
  logic [2:0] o_state;

  tft_panel_seq #(.T_PWR(4), .T_DISP(3), .PRE_FRAMES(2), .BL_STEP(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_screenend(i_screenend),
    .i_bl_level(i_bl_level), .o_avdd_en(o_avdd_en), .o_tg_rst(o_tg_rst),
    .o_pix_en(o_pix_en), .o_disp(o_disp), .o_bl_pwm(o_bl_pwm), .o_ready(o_ready),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          se_phase = 0;
  logic        se_at_edge = 1'b0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] vec(input logic [2:0] s, input logic a, input logic t,
                                      input logic p, input logic d, input logic r);
    return {24'd0, s, a, t, p, d, r};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {24'd0, o_state, o_avdd_en, o_tg_rst, o_pix_en, o_disp, o_ready};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
    end
  endtask

  // Screen-end pulse every 20 cycles, advanced in lockstep with the stimulus.
  task automatic tick();
    se_at_edge = i_screenend;
    @(posedge i_clk);
    #1;
    se_phase    = (se_phase == 19) ? 0 : se_phase + 1;
    i_screenend = (se_phase == 19);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      hi += int'(o_bl_pwm);
    end
  endtask

  int n;

  initial begin
    ticks(3);
    i_rst_n = 1'b1;
    expect_val("reset_vec", vec(3'd0, 0, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("reset_pwm_hi", 32'd0);
    count_pwm(512, n); check(32'(n));

    i_bl_level = 8'd8;
    i_en = 1'b1;
    expect_val("pwr_up", vec(3'd1, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("pwr_up_hold", vec(3'd1, 1, 1, 0, 0, 0));
    ticks(3); check(obs_vec());
    expect_val("tg_run", vec(3'd2, 1, 0, 1, 0, 0));
    tick(); check(obs_vec());

    expect_val("tg_frames", 32'd2);
    expect_val("disp_on", vec(3'd3, 1, 0, 1, 1, 0));
    expect_val("disp_after_se", 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n += int'(se_at_edge);
      if (o_disp) break;
    end
    check(32'(n)); check(obs_vec()); check(32'(se_at_edge));
    expect_val("disp_on_hold", vec(3'd3, 1, 0, 1, 1, 0));
    ticks(2); check(obs_vec());
    expect_val("bl_up", vec(3'd4, 1, 0, 1, 1, 0));
    tick(); check(obs_vec());

    expect_val("bl_up_cycles", 32'd17);
    expect_val("on_vec", vec(3'd5, 1, 0, 1, 1, 1));
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); n++;
      if (o_ready) break;
    end
    check(32'(n)); check(obs_vec());
    expect_val("pwm_8", 32'd8);
    tick(); count_pwm(256, n); check(32'(n));

    i_bl_level = 8'd200;
    expect_val("pwm_200", 32'd200);
    ticks(2); count_pwm(256, n); check(32'(n));
    expect_val("on_after_200", vec(3'd5, 1, 0, 1, 1, 1));
    check(obs_vec());

    i_bl_level = 8'd8;
    ticks(2);
    i_en = 1'b0;
    expect_val("bl_down", vec(3'd6, 1, 0, 1, 1, 0));
    tick(); check(obs_vec());
    expect_val("bl_down_cycles", 32'd17);
    expect_val("pwr_dn_a", vec(3'd7, 1, 0, 1, 1, 0));
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); n++;
      if (o_state == 3'd7) break;
    end
    check(32'(n)); check(obs_vec());

    expect_val("disp_off_on_se", 32'd1);
    expect_val("pwr_dn_b", vec(3'd7, 1, 0, 1, 0, 0));
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!o_disp) break;
    end
    check(32'(se_at_edge)); check(obs_vec());
    expect_val("pwr_dn_b_hold", vec(3'd7, 1, 0, 1, 0, 0));
    ticks(2); check(obs_vec());
    expect_val("pwr_dn_c", vec(3'd7, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("pwr_dn_c_hold", vec(3'd7, 1, 1, 0, 0, 0));
    ticks(3); check(obs_vec());
    expect_val("off_again", vec(3'd0, 0, 1, 0, 0, 0));
    tick(); check(obs_vec());

    i_en = 1'b1;
    expect_val("g_pwr_up", vec(3'd1, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("g_tg_run", vec(3'd2, 1, 0, 1, 0, 0));
    ticks(4); check(obs_vec());
    i_en = 1'b0;
    expect_val("g_bl_down", vec(3'd6, 1, 0, 1, 0, 0));
    tick(); check(obs_vec());
    i_en = 1'b1;
    expect_val("g_pwr_dn_c", vec(3'd7, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("g_pwr_dn_c_hold", vec(3'd7, 1, 1, 0, 0, 0));
    ticks(3); check(obs_vec());
    expect_val("g_off", vec(3'd0, 0, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("g_restart", vec(3'd1, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());

    expect_val("bl_up_again", 32'd4);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (o_state == 3'd4) break;
    end
    check(32'(o_state));
    ticks(3);
    #2 i_rst_n = 1'b0;
    #1;
    expect_val("async_rst_vec", vec(3'd0, 0, 1, 0, 0, 0));
    check(obs_vec());
    expect_val("async_rst_pwm", 32'd0);
    check(32'(o_bl_pwm));
    #1 i_rst_n = 1'b1;
    expect_val("replay_pwr_up", vec(3'd1, 1, 1, 0, 0, 0));
    tick(); check(obs_vec());
    expect_val("replay_ready", 32'd5);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_ready) break;
    end
    check(32'(o_state));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
